// File: rtl/mem_stage_bridge_pkg.sv
// Shared constants and types for the M-stage memory bridge: op codes, exception
// codes, address window layout and the device FSM state type.
package mem_stage_bridge_pkg;

  localparam logic [3:0] MEM_OP_LW   = 4'd0;
  localparam logic [3:0] MEM_OP_SB   = 4'd1;
  localparam logic [3:0] MEM_OP_SH   = 4'd2;
  localparam logic [3:0] MEM_OP_SW   = 4'd3;
  localparam logic [3:0] MEM_OP_LB   = 4'd4;
  localparam logic [3:0] MEM_OP_LBU  = 4'd5;
  localparam logic [3:0] MEM_OP_LH   = 4'd6;
  localparam logic [3:0] MEM_OP_LHU  = 4'd7;
  localparam logic [3:0] MEM_OP_MFC0 = 4'd8;
  localparam logic [3:0] MEM_OP_MTC0 = 4'd9;
  localparam logic [3:0] MEM_OP_NONE = 4'd10;
  localparam logic [3:0] MEM_OP_ERET = 4'd11;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] DM_BYTES_DEF    = 32'h0000_3000;
  localparam logic [31:0] TIMER_BASE_DEF  = 32'h0000_7F00;
  localparam logic [31:0] TIMER_BYTES     = 32'd12;
  localparam logic [31:0] TIMER_COUNT_OFF = 32'd8;
  localparam logic [31:0] UART_BASE_DEF   = 32'h0000_7F30;
  localparam logic [31:0] UART_BYTES      = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dev_state_e;

endpackage

// File: rtl/mem_stage_bridge_load_ext.sv
// Load result formatter: picks the byte/half addressed by the captured offset
// and sign- or zero-extends it; word loads pass through.
module mem_stage_bridge_load_ext
  import mem_stage_bridge_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*off +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (op)
      MEM_OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: data = {24'd0, byte_sel};
      MEM_OP_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: data = {16'd0, half_sel};
      default:    data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage_bridge.sv
// M-stage memory responder: address checks, byte-enabled DM stores, 1-cycle DM
// loads, and a req/ack device transaction that stalls the pipeline while in flight.
module mem_stage_bridge
  import mem_stage_bridge_pkg::*;
#(
  parameter logic [31:0] DM_BYTES   = DM_BYTES_DEF,
  parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEF,
  parameter logic [31:0] UART_BASE  = UART_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_op,
  input  logic        flush,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        dev_req,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  localparam logic [31:0] TIMER_COUNT = TIMER_BASE + TIMER_COUNT_OFF;

  dev_state_e  state_q, state_d;
  logic        dev_req_q, dev_req_d;
  logic        dev_we_q, dev_we_d;
  logic [31:0] dev_addr_q, dev_addr_d;
  logic [31:0] dev_wdata_q, dev_wdata_d;
  logic [31:0] dev_rdata_q, dev_rdata_d;
  logic        dev_load_q, dev_load_d;
  logic        ld_pend_q, ld_pend_d;
  logic [3:0]  ld_op_q, ld_op_d;
  logic [1:0]  ld_off_q, ld_off_d;

  logic is_load, is_store, is_word, is_half, req;
  logic misalign, in_dm, in_tmr, in_uart, in_dev, dev_bad, exc, dm_go, dev_go;
  logic [3:0]  be_c;
  logic [31:0] st_data_c, ld_word;

  // Request qualification and address decode; exceptions gate every side effect.
  always_comb begin
    is_load  = mem_op inside {MEM_OP_LW, MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU};
    is_store = mem_op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
    is_word  = (mem_op == MEM_OP_LW) || (mem_op == MEM_OP_SW);
    is_half  = mem_op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH};
    req      = (is_load || is_store) && !flush && (state_q == ST_IDLE);
    misalign = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    in_dm    = addr < DM_BYTES;
    in_tmr   = (addr >= TIMER_BASE) && (addr < TIMER_BASE + TIMER_BYTES);
    in_uart  = (addr >= UART_BASE) && (addr < UART_BASE + UART_BYTES);
    in_dev   = in_tmr || in_uart;
    dev_bad  = (in_dev && !is_word) || (is_store && in_tmr && (addr[31:2] == TIMER_COUNT[31:2]));
    exc      = req && (misalign || !(in_dm || in_dev) || dev_bad);
    dm_go    = req && !exc && in_dm;
    dev_go   = req && !exc && in_dev;
  end

  always_comb begin
    be_c      = 4'b0000;
    st_data_c = wdata;
    case (mem_op)
      MEM_OP_SB: begin
        be_c      = 4'b0001 << addr[1:0];
        st_data_c = {4{wdata[7:0]}};
      end
      MEM_OP_SH: begin
        be_c      = 4'b0011 << {addr[1], 1'b0};
        st_data_c = {2{wdata[15:0]}};
      end
      MEM_OP_SW: be_c = 4'hF;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dev_go) state_d = ST_WAIT;
      ST_WAIT: if (dev_ack) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: device request registers and load capture.
  always_comb begin
    dev_req_d   = dev_req_q;
    dev_we_d    = dev_we_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    dev_rdata_d = dev_rdata_q;
    dev_load_d  = dev_load_q;
    ld_pend_d   = dm_go && is_load;
    ld_op_d     = ld_op_q;
    ld_off_d    = ld_off_q;
    if ((dm_go || dev_go) && is_load) begin
      ld_op_d  = mem_op;
      ld_off_d = addr[1:0];
    end
    if (dev_go) begin
      dev_req_d   = 1'b1;
      dev_we_d    = is_store;
      dev_addr_d  = {addr[31:2], 2'b00};
      dev_wdata_d = wdata;
      dev_load_d  = is_load;
    end
    if ((state_q == ST_WAIT) && dev_ack) begin
      dev_req_d   = 1'b0;
      dev_rdata_d = dev_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dev_req_q   <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      dev_rdata_q <= '0;
      dev_load_q  <= 1'b0;
      ld_pend_q   <= 1'b0;
      ld_op_q     <= MEM_OP_LW;
      ld_off_q    <= 2'b00;
    end else begin
      dev_req_q   <= dev_req_d;
      dev_we_q    <= dev_we_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      dev_rdata_q <= dev_rdata_d;
      dev_load_q  <= dev_load_d;
      ld_pend_q   <= ld_pend_d;
      ld_op_q     <= ld_op_d;
      ld_off_q    <= ld_off_d;
    end
  end

  always_comb begin
    dm_addr     = {addr[31:2], 2'b00};
    dm_be       = (dm_go && is_store) ? be_c : 4'b0000;
    dm_wdata    = st_data_c;
    dev_req     = dev_req_q;
    dev_we      = dev_we_q;
    dev_addr    = dev_addr_q;
    dev_wdata   = dev_wdata_q;
    stall       = ((state_q == ST_IDLE) && dev_go) || (state_q == ST_WAIT);
    rdata_valid = ld_pend_q || ((state_q == ST_DONE) && dev_load_q);
    exc_valid   = exc;
    exc_code    = exc ? (is_store ? EXC_ADES : EXC_ADEL) : 5'd0;
    // Device loads are word-only, so the captured op/offset pass dev data through.
    ld_word     = (state_q == ST_DONE) ? dev_rdata_q : dm_rdata;
  end

  mem_stage_bridge_load_ext u_load_ext (
    .op   (ld_op_q),
    .off  (ld_off_q),
    .word (ld_word),
    .data (rdata)
  );

endmodule

// File: tb/tb_mem_stage_bridge.sv
// Self-checking bench for mem_stage_bridge: directed vectors plus randomized DM
// and device traffic compared against an arithmetic reference model.
module tb_mem_stage_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_op;
  logic        flush;
  logic [31:0] addr, wdata, dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dev_req, dev_we, dev_ack, stall, rdata_valid, exc_valid;
  logic [31:0] dev_addr, dev_wdata, dev_rdata, rdata;
  logic [4:0]  exc_code;

  int total = 0;
  int bad   = 0;

  localparam int C_NONE = 0, C_EXC = 1, C_DM = 2, C_DEV = 3;

  mem_stage_bridge dut (
    .clk(clk), .reset(reset), .mem_op(mem_op), .flush(flush), .addr(addr), .wdata(wdata),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_ack(dev_ack), .dev_rdata(dev_rdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .exc_valid(exc_valid), .exc_code(exc_code)
  );

  always #5 clk = ~clk;

  // ---- reference model ----
  function automatic bit m_store(input int op);
    return (op >= 1 && op <= 3);
  endfunction

  function automatic int m_size(input int op);
    if (op == 0 || op == 3) return 4;
    if (op == 2 || op == 6 || op == 7) return 2;
    return 1;
  endfunction

  function automatic int m_cat(input int op, input longint a);
    bit dm, tmr, uart;
    if (op > 7) return C_NONE;
    dm   = a < 'h3000;
    tmr  = a >= 'h7F00 && a < 'h7F0C;
    uart = a >= 'h7F30 && a < 'h7F40;
    if (a % m_size(op) != 0) return C_EXC;
    if (!(dm || tmr || uart)) return C_EXC;
    if ((tmr || uart) && m_size(op) != 4) return C_EXC;
    if (m_store(op) && a == 'h7F08) return C_EXC;
    return (tmr || uart) ? C_DEV : C_DM;
  endfunction

  function automatic logic [3:0] m_be(input int op, input longint a);
    case (op)
      1: return 4'(1 << (a % 4));
      2: return 4'(3 << (a % 4));
      3: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input int op, input logic [31:0] w);
    longint b = w & 'hFF, h = w & 'hFFFF;
    case (op)
      1: return 32'(b * 'h01010101);
      2: return 32'(h * 'h00010001);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input int op, input int off, input logic [31:0] w);
    longint v = longint'(w) >> (8 * off);
    longint b = v & 'hFF, h = v & 'hFFFF;
    case (op)
      4: return 32'(b > 127 ? b - 256 : b);
      5: return 32'(b);
      6: return 32'(h > 32767 ? h - 65536 : h);
      7: return 32'(h);
      default: return w;
    endcase
  endfunction

  // ---- helpers ----
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    mem_op = 4'd10; flush = 0; addr = 0; wdata = 0; dev_ack = 0; dev_rdata = 0; dm_rdata = 0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    idle_in(); reset = 1; tick(); tick();
    total++; if (stall !== 1'b0 || dev_req !== 1'b0 || dev_we !== 1'b0) begin bad++;
      $display("FAIL reset_ctl stall=%b dev_req=%b dev_we=%b want 0 0 0", stall, dev_req, dev_we); end
    total++; if (dev_addr !== 32'd0 || dev_wdata !== 32'd0) begin bad++;
      $display("FAIL reset_dev dev_addr=%h dev_wdata=%h want 0 0", dev_addr, dev_wdata); end
    total++; if (rdata_valid !== 1'b0 || exc_valid !== 1'b0 || dm_be !== 4'd0) begin bad++;
      $display("FAIL reset_out rv=%b exc=%b be=%h want 0 0 0", rdata_valid, exc_valid, dm_be); end
    reset = 0; tick();
  endtask

  task automatic test_store_lanes();
    mem_op = 4'd1; addr = 32'h13; wdata = 32'hAB; #1;
    total++; if (dm_be !== 4'b1000 || dm_wdata !== 32'hABABABAB || exc_valid !== 1'b0) begin bad++;
      $display("FAIL sb_13 be=%b wd=%h exc=%b want 1000 abababab 0", dm_be, dm_wdata, exc_valid); end
    total++; if (dm_addr !== 32'h10) begin bad++;
      $display("FAIL sb_13_addr got=%h want 00000010", dm_addr); end
    tick(); idle_in(); tick();
  endtask

  task automatic test_load_ext();
    logic [3:0]  ops  [3] = '{4'd4, 4'd5, 4'd6};
    logic [31:0] adrs [3] = '{32'h2, 32'h3, 32'h2};
    logic [31:0] exps [3] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF};
    for (int i = 0; i < 3; i++) begin
      mem_op = ops[i]; addr = adrs[i]; tick();
      idle_in(); dm_rdata = 32'h80FF7F01; #1;
      total++; if (rdata_valid !== 1'b1 || rdata !== exps[i]) begin bad++;
        $display("FAIL load_ext_%0d rv=%b rdata=%h want 1 %h", i, rdata_valid, rdata, exps[i]); end
      tick();
    end
  endtask

  task automatic test_exceptions();
    logic [3:0]  ops  [4] = '{4'd0, 4'd2, 4'd3, 4'd0};
    logic [31:0] adrs [4] = '{32'h6, 32'h7F30, 32'h7F08, 32'h4000};
    logic [4:0]  code [4] = '{5'd4, 5'd5, 5'd5, 5'd4};
    for (int i = 0; i < 4; i++) begin
      mem_op = ops[i]; addr = adrs[i]; wdata = 32'hFFFFFFFF; #1;
      total++; if (exc_valid !== 1'b1 || exc_code !== code[i] || dm_be !== 4'd0 || stall !== 1'b0) begin bad++;
        $display("FAIL exc_%0d exc=%b code=%0d be=%h stall=%b want 1 %0d 0 0", i, exc_valid, exc_code, dm_be, stall, code[i]); end
      tick();
      total++; if (dev_req !== 1'b0 || rdata_valid !== 1'b0) begin bad++;
        $display("FAIL exc_side_%0d dev_req=%b rv=%b want 0 0", i, dev_req, rdata_valid); end
      idle_in();
    end
    tick();
  endtask

  task automatic test_random_dm(input int n);
    bit pv = 0; int pop = 0, poff = 0, cat, op, sel;
    logic [31:0] a, exp_r;
    for (int it = 0; it < n; it++) begin
      dm_rdata = $urandom; wdata = $urandom; flush = ($urandom_range(0, 7) == 0);
      op = $urandom_range(0, 11); sel = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: a = $urandom_range(0, 'h2FFF);
        3:       a = $urandom_range('h3000, 'h7EFF);
        4:       a = ($urandom_range(0, 1) != 0) ? 32'h7F00 + $urandom_range(0, 11) : 32'h7F30 + $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      cat = m_cat(op, a);
      if (cat == C_DEV) begin op = 10; cat = C_NONE; end
      if (flush) cat = C_NONE;
      mem_op = 4'(op); addr = a; #1;
      total++; if (rdata_valid !== pv) begin bad++;
        $display("FAIL rnd_rv it=%0d got=%b want %b", it, rdata_valid, pv); end
      if (pv) begin
        exp_r = m_load(pop, poff, dm_rdata);
        total++; if (rdata !== exp_r) begin bad++;
          $display("FAIL rnd_rdata it=%0d op=%0d off=%0d got=%h want %h", it, pop, poff, rdata, exp_r); end
      end
      total++; if (exc_valid !== (cat == C_EXC) || exc_code !== ((cat == C_EXC) ? (m_store(op) ? 5'd5 : 5'd4) : 5'd0)) begin bad++;
        $display("FAIL rnd_exc it=%0d op=%0d addr=%h exc=%b code=%0d", it, op, a, exc_valid, exc_code); end
      total++; if (dm_be !== ((cat == C_DM) ? m_be(op, a) : 4'd0) || stall !== 1'b0) begin bad++;
        $display("FAIL rnd_be it=%0d op=%0d addr=%h be=%h stall=%b", it, op, a, dm_be, stall); end
      if (cat == C_DM && m_store(op)) begin
        total++; if (dm_wdata !== m_wd(op, wdata)) begin bad++;
          $display("FAIL rnd_wd it=%0d op=%0d got=%h want %h", it, op, dm_wdata, m_wd(op, wdata)); end
      end
      pv = (cat == C_DM) && !m_store(op); pop = op; poff = int'(a % 4);
      @(posedge clk); #1;
    end
    idle_in(); tick();
  endtask

  task automatic test_device(input int op, input logic [31:0] a, input logic [31:0] wd,
                             input int delay, input logic [31:0] ack_d, input bit flush_wait);
    int stalls = 0; bit ld = !m_store(op);
    mem_op = 4'(op); addr = a; wdata = wd; #1;
    total++; if (stall !== 1'b1 || dev_req !== 1'b0 || exc_valid !== 1'b0 || dm_be !== 4'd0) begin bad++;
      $display("FAIL dev_issue addr=%h stall=%b req=%b exc=%b be=%h", a, stall, dev_req, exc_valid, dm_be); end
    stalls += (stall === 1'b1);
    tick();
    for (int k = 1; k <= delay; k++) begin
      if (flush_wait) flush = 1;
      #1;
      total++; if (dev_req !== 1'b1 || dev_we !== !ld || dev_addr !== (a & ~32'h3) || (!ld && dev_wdata !== wd)) begin bad++;
        $display("FAIL dev_wait k=%0d req=%b we=%b addr=%h wd=%h", k, dev_req, dev_we, dev_addr, dev_wdata); end
      total++; if (exc_valid !== 1'b0 || dm_be !== 4'd0) begin bad++;
        $display("FAIL dev_wait_side k=%0d exc=%b be=%h want 0 0", k, exc_valid, dm_be); end
      stalls += (stall === 1'b1);
      if (k == delay) begin dev_ack = 1; dev_rdata = ack_d; end
      tick();
      dev_ack = 0; dev_rdata = $urandom;
    end
    flush = 0; #1;
    total++; if (stall !== 1'b0 || dev_req !== 1'b0 || rdata_valid !== ld) begin bad++;
      $display("FAIL dev_done stall=%b req=%b rv=%b want 0 0 %b", stall, dev_req, rdata_valid, ld); end
    if (ld) begin
      total++; if (rdata !== ack_d) begin bad++;
        $display("FAIL dev_rdata got=%h want %h", rdata, ack_d); end
    end
    total++; if (stalls !== delay + 1) begin bad++;
      $display("FAIL dev_stall_len got=%0d want %0d", stalls, delay + 1); end
    idle_in(); tick();
    total++; if (stall !== 1'b0 || rdata_valid !== 1'b0 || dev_req !== 1'b0) begin bad++;
      $display("FAIL dev_after stall=%b rv=%b req=%b want 0 0 0", stall, rdata_valid, dev_req); end
  endtask

  task automatic test_random_dev(input int n);
    logic [31:0] a;
    int op;
    for (int i = 0; i < n; i++) begin
      op = ($urandom_range(0, 1) != 0) ? 3 : 0;
      a  = ($urandom_range(0, 1) != 0) ? 32'h7F30 + 4 * $urandom_range(0, 3) : 32'h7F00 + 4 * $urandom_range(0, 2);
      if (op == 3 && a == 32'h7F08) a = 32'h7F04;
      test_device(op, a, $urandom, $urandom_range(1, 5), $urandom, $urandom_range(0, 1) != 0);
    end
  endtask

  task automatic test_reset_in_wait();
    mem_op = 4'd3; addr = 32'h7F34; wdata = 32'h99; tick(); tick();
    reset = 1; idle_in(); tick();
    total++; if (dev_req !== 1'b0 || stall !== 1'b0) begin bad++;
      $display("FAIL rst_wait req=%b stall=%b want 0 0", dev_req, stall); end
    reset = 0; dev_ack = 1; dev_rdata = 32'hDEAD; tick(); dev_ack = 0; #1;
    total++; if (dev_req !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0) begin bad++;
      $display("FAIL stray_ack req=%b stall=%b rv=%b want 0 0 0", dev_req, stall, rdata_valid); end
    tick();
  endtask

  initial begin
    idle_in(); reset = 1;
    test_reset();
    test_store_lanes();
    test_load_ext();
    test_exceptions();
    test_random_dm(150);
    test_device(3, 32'h7F34, 32'h55, 3, 32'h0, 0);
    test_device(0, 32'h7F08, 32'h0, 2, 32'h1234, 1);
    test_random_dev(8);
    test_reset_in_wait();
    test_random_dm(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
